// File: rtl/sram_wb_host_bridge.sv
// sram_wb_host_bridge
//   Upstream stage in front of the secure-memory SRAM Wishbone slave wrapper.
//   It decodes a 2 KB byte-addressed window on the Caravel-side bus, registers
//   each hit, and reissues it downstream as one word-addressed Wishbone cycle.
//   Read data and ack (or err) are returned upstream one cycle after the
//   downstream ack. If upstream drops cyc mid-transfer, the downstream cycle
//   still completes, but nothing is returned upstream.
//
//   Optional feature macro: SRAM_BRIDGE_TIMEOUT_EN
//     When defined, a watchdog abandons a BUSY transfer after TIMEOUT_CYC
//     cycles without an ack and reports m_wb_err_o. When it is undefined,
//     m_wb_err_o is tied to 0 and BUSY waits indefinitely.
//
//   Ports
//     wb_clk_i, rst_n             : clock, asynchronous active-low reset
//     m_wb_*                      : upstream (Caravel master side) Wishbone
//     s_wb_*                      : downstream (SRAM wrapper side) Wishbone
//     busy_o                      : high while a transfer is in flight (state != IDLE)
module sram_wb_host_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK    = 32'hFFFF_F800,
  parameter int          SRAM_ADDR_WD = 9,
  parameter int          SRAM_DATA_WD = 32,
  parameter int          TIMEOUT_CYC  = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      rst_n,
  input  logic                      m_wb_cyc_i,
  input  logic                      m_wb_stb_i,
  input  logic                      m_wb_we_i,
  input  logic [31:0]               m_wb_adr_i,
  input  logic [SRAM_DATA_WD-1:0]   m_wb_dat_i,
  input  logic [SRAM_DATA_WD/8-1:0] m_wb_sel_i,
  output logic [SRAM_DATA_WD-1:0]   m_wb_dat_o,
  output logic                      m_wb_ack_o,
  output logic                      m_wb_err_o,
  output logic                      s_wb_cyc_o,
  output logic                      s_wb_stb_o,
  output logic                      s_wb_we_o,
  output logic [SRAM_ADDR_WD-1:0]   s_wb_adr_o,
  output logic [SRAM_DATA_WD-1:0]   s_wb_dat_o,
  output logic [SRAM_DATA_WD/8-1:0] s_wb_sel_o,
  input  logic [SRAM_DATA_WD-1:0]   s_wb_dat_i,
  input  logic                      s_wb_ack_i,
  output logic                      busy_o
);

  localparam int SEL_WD = SRAM_DATA_WD / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q,  state_d;
  logic                    s_cyc_q,  s_cyc_d;
  logic                    s_stb_q,  s_stb_d;
  logic                    s_we_q,   s_we_d;
  logic [SRAM_ADDR_WD-1:0] s_adr_q,  s_adr_d;
  logic [SRAM_DATA_WD-1:0] s_dat_q,  s_dat_d;
  logic [SEL_WD-1:0]       s_sel_q,  s_sel_d;
  logic [SRAM_DATA_WD-1:0] m_dat_q,  m_dat_d;
  logic                    m_ack_q,  m_ack_d;
  logic                    abort_q,  abort_d;
  logic                    hit_s;
  logic                    abort_now_s;

`ifdef SRAM_BRIDGE_TIMEOUT_EN
  localparam int TMO_WD = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_WD-1:0] TMO_LAST = TMO_WD'(TIMEOUT_CYC - 1);
  logic [TMO_WD-1:0]       tmo_q, tmo_d;
  logic                    m_err_q, m_err_d;
`endif

  assign hit_s = m_wb_cyc_i & m_wb_stb_i & ((m_wb_adr_i & ADDR_MASK) == BASE_ADDR);

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    s_cyc_d     = s_cyc_q;
    s_stb_d     = s_stb_q;
    s_we_d      = s_we_q;
    s_adr_d     = s_adr_q;
    s_dat_d     = s_dat_q;
    s_sel_d     = s_sel_q;
    m_dat_d     = m_dat_q;
    m_ack_d     = 1'b0;
    abort_d     = abort_q;
    abort_now_s = abort_q;
`ifdef SRAM_BRIDGE_TIMEOUT_EN
    tmo_d       = tmo_q;
    m_err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d = ST_BUSY;
          s_cyc_d = 1'b1;
          s_stb_d = 1'b1;
          s_we_d  = m_wb_we_i;
          s_adr_d = m_wb_adr_i[SRAM_ADDR_WD+1:2];
          s_dat_d = m_wb_dat_i;
          s_sel_d = m_wb_sel_i;
          abort_d = 1'b0;
`ifdef SRAM_BRIDGE_TIMEOUT_EN
          tmo_d   = {TMO_WD{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A cyc drop in the completing cycle must already suppress the response.
        abort_now_s = abort_q | ~m_wb_cyc_i;
        abort_d     = abort_now_s;
        if (s_wb_ack_i) begin
          m_dat_d = s_we_q ? {SRAM_DATA_WD{1'b0}} : s_wb_dat_i;
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          m_ack_d = ~abort_now_s;
          state_d = ST_RESP;
`ifdef SRAM_BRIDGE_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          // This cycle is the TIMEOUT_CYC-th BUSY cycle without an ack.
          m_dat_d = {SRAM_DATA_WD{1'b0}};
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          m_err_d = ~abort_now_s;
          state_d = ST_RESP;
        end else begin
          tmo_d   = tmo_q + {{(TMO_WD-1){1'b0}}, 1'b1};
        end
`else
        end else begin
          state_d = ST_BUSY;
        end
`endif
      end
      ST_RESP: begin
        // Whatever the upstream master still presents here is not resampled.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        s_cyc_d = 1'b0;
        s_stb_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_cyc_q <= 1'b0;
      s_stb_q <= 1'b0;
      s_we_q  <= 1'b0;
      s_adr_q <= {SRAM_ADDR_WD{1'b0}};
      s_dat_q <= {SRAM_DATA_WD{1'b0}};
      s_sel_q <= {SEL_WD{1'b0}};
      m_dat_q <= {SRAM_DATA_WD{1'b0}};
      m_ack_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cyc_q <= s_cyc_d;
      s_stb_q <= s_stb_d;
      s_we_q  <= s_we_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      s_sel_q <= s_sel_d;
      m_dat_q <= m_dat_d;
      m_ack_q <= m_ack_d;
      abort_q <= abort_d;
    end
  end

`ifdef SRAM_BRIDGE_TIMEOUT_EN
  // Watchdog counter and error pulse registers.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q   <= {TMO_WD{1'b0}};
      m_err_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      m_err_q <= m_err_d;
    end
  end
  assign m_wb_err_o = m_err_q;
`else
  assign m_wb_err_o = 1'b0;
`endif

  assign m_wb_dat_o = m_dat_q;
  assign m_wb_ack_o = m_ack_q;
  assign s_wb_cyc_o = s_cyc_q;
  assign s_wb_stb_o = s_stb_q;
  assign s_wb_we_o  = s_we_q;
  assign s_wb_adr_o = s_adr_q;
  assign s_wb_dat_o = s_dat_q;
  assign s_wb_sel_o = s_sel_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule
